// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, runs one req/ack fetch at a time against a
// variable-latency instruction memory and fills the one-entry ValidF/InstrF/PCF slot.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        StallF,
  output logic        fetch_err
);

  localparam int BW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_IDLE = 3'd1,
    S_WAIT = 3'd2,
    S_KILL = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic [31:0]   req_addr_r, req_addr_s;
  logic [31:0]   instr_r, instr_s;
  logic [31:0]   pcf_r, pcf_s;
  logic          valid_r, valid_s;
  logic          err_r, err_s;
  logic [BW-1:0] boot_cnt_r, boot_cnt_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;

  logic        consume_s, can_accept_s, boot_done_s;
  logic        req_s, fill_s;
  logic [31:0] fill_pc_s, target_s, pc_inc_s;

  assign target_s     = {PCTargetE[31:2], 2'b00};
  assign pc_inc_s     = pc_r + 32'd4;
  assign consume_s    = valid_r & ~StallD;
  assign can_accept_s = ~valid_r | consume_s;
  assign boot_done_s  = (boot_cnt_r == BOOT_LAST);

  assign imem_req  = req_s;
  assign imem_addr = ((state_r == S_WAIT) || (state_r == S_KILL) || (state_r == S_ERR)) ? req_addr_r : pc_r;
  assign StallF    = ~PCSrcE & ~(req_s & imem_ack & (state_r != S_KILL));
  assign ValidF    = valid_r;
  assign InstrF    = instr_r;
  assign PCF       = pcf_r;
  assign fetch_err = err_r;

  // Next-state, request and PC selection; a finished BOOT behaves exactly like IDLE.
  always_comb begin
    state_s    = state_r;
    req_addr_s = req_addr_r;
    boot_cnt_s = boot_cnt_r;
    to_cnt_s   = to_cnt_r;
    err_s      = err_r;
    req_s      = 1'b0;
    fill_s     = 1'b0;
    fill_pc_s  = pc_r;
    case (state_r)
      S_BOOT, S_IDLE: begin
        if ((state_r == S_BOOT) && !boot_done_s) begin
          boot_cnt_s = boot_cnt_r + BW'(1);
        end else begin
          req_s = can_accept_s & ~PCSrcE;
          if (req_s) begin
            req_addr_s = pc_r;
            if (imem_ack) begin
              fill_s    = 1'b1;
              fill_pc_s = pc_r;
              state_s   = S_IDLE;
            end else begin
              to_cnt_s = {TW{1'b0}};
              state_s  = S_WAIT;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        req_s = 1'b1;
        if (imem_ack) begin
          to_cnt_s = {TW{1'b0}};
          state_s  = S_IDLE;
          if (!PCSrcE) begin
            fill_s    = 1'b1;
            fill_pc_s = req_addr_r;
          end else begin
            fill_s = 1'b0;
          end
        end else if (PCSrcE) begin
          to_cnt_s = {TW{1'b0}};
          state_s  = S_KILL;
        end else if (to_cnt_r == TO_LAST) begin
          err_s   = 1'b1;
          state_s = S_ERR;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1);
        end
      end
      S_KILL: begin
        // Stale request must still complete; its data is dropped.
        req_s = 1'b1;
        if (imem_ack) begin
          to_cnt_s = {TW{1'b0}};
          state_s  = S_IDLE;
        end else if (to_cnt_r == TO_LAST) begin
          err_s   = 1'b1;
          state_s = S_ERR;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1);
        end
      end
      S_ERR: begin
        err_s = 1'b1;
      end
      default: begin
        err_s   = 1'b1;
        state_s = S_ERR;
      end
    endcase

    if (PCSrcE && (state_r != S_ERR)) begin
      pc_s = target_s;
    end else if (fill_s) begin
      pc_s = pc_inc_s;
    end else begin
      pc_s = pc_r;
    end
  end

  // Output slot: flush on redirect or error, refill beats consume.
  always_comb begin
    valid_s = valid_r;
    instr_s = instr_r;
    pcf_s   = pcf_r;
    if (state_r == S_ERR) begin
      valid_s = 1'b0;
    end else if (PCSrcE) begin
      valid_s = 1'b0;
    end else if (fill_s) begin
      valid_s = 1'b1;
      instr_s = imem_rdata;
      pcf_s   = fill_pc_s;
    end else if (consume_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_BOOT;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      boot_cnt_r <= {BW{1'b0}};
      to_cnt_r   <= {TW{1'b0}};
      valid_r    <= 1'b0;
      instr_r    <= 32'h0000_0000;
      pcf_r      <= 32'h0000_0000;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      req_addr_r <= req_addr_s;
      boot_cnt_r <= boot_cnt_s;
      to_cnt_r   <= to_cnt_s;
      valid_r    <= valid_s;
      instr_r    <= instr_s;
      pcf_r      <= pcf_s;
      err_r      <= err_s;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model tracks the PC,
// the single outstanding fetch and the output slot; a behavioural memory answers requests.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int BOOT = 2;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, PCSrcE, imem_ack;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidF, StallF, fetch_err;
  logic [31:0] imem_addr, InstrF, PCF;

  fetch_sequencer #(.RESET_PC(RST_PC), .BOOT_CYCLES(BOOT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .StallF(StallF), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  // stimulus knobs
  int lat_mode;   // -1: never ack, 0..4 fixed latency, 99: random latency
  int stall_pct;
  int redir_pct;

  // memory state
  int mem_cnt;
  int mem_lat;

  // reference model
  int          boot_left;
  int          m_wait;
  logic [31:0] m_pc, m_out_addr, m_instr, m_pcf;
  bit          m_out, m_killed, m_err, m_valid;

  function automatic int pick_lat();
    if (lat_mode == 99) return int'($urandom_range(0, 4));
    return lat_mode;
  endfunction

  task automatic model_reset();
    boot_left = BOOT;
    m_pc = RST_PC;
    m_out = 1'b0; m_killed = 1'b0; m_err = 1'b0; m_valid = 1'b0;
    m_out_addr = RST_PC; m_instr = 32'h0; m_pcf = 32'h0; m_wait = 0;
    mem_cnt = 0; mem_lat = pick_lat();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ValidF"}, {31'd0, ValidF}, 32'd0);
    check_eq({tag, "_InstrF"}, InstrF, 32'd0);
    check_eq({tag, "_PCF"}, PCF, 32'd0);
    check_eq({tag, "_fetch_err"}, {31'd0, fetch_err}, 32'd0);
    check_eq({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    check_eq({tag, "_imem_addr"}, imem_addr, RST_PC);
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step();
    logic exp_req, ack, fill, consume;
    logic [31:0] fill_addr;
    StallD = (int'($urandom_range(0, 99)) < stall_pct);
    PCSrcE = (int'($urandom_range(0, 99)) < redir_pct);
    PCTargetE = $urandom_range(0, 1) ? 32'h0000_0103 : $urandom;
    imem_ack = 1'b0;
    #1;
    if (m_err || boot_left > 0) exp_req = 1'b0;
    else if (m_out) exp_req = 1'b1;
    else exp_req = (!m_valid || !StallD) && !PCSrcE;
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, m_out ? m_out_addr : m_pc);
    ack = imem_req && (lat_mode >= 0) && (mem_cnt >= mem_lat);
    if (imem_req) imem_ack = ack;
    else imem_ack = ($urandom_range(0, 3) == 0);   // must be ignored
    imem_rdata = ack ? mem_word(imem_addr) : $urandom;
    ack = ack && exp_req;
    #1;
    check_eq("StallF", {31'd0, StallF}, {31'd0, (!PCSrcE && !(ack && !m_killed))});
    @(posedge clk);
    if (imem_req) begin
      if (imem_ack) begin mem_cnt = 0; mem_lat = pick_lat(); end
      else mem_cnt++;
    end
    consume = m_valid && !StallD;
    fill = 1'b0;
    fill_addr = m_pc;
    if (!m_err) begin
      if (boot_left > 0) boot_left--;
      else if (m_out) begin
        if (ack) begin
          if (!m_killed && !PCSrcE) begin fill = 1'b1; fill_addr = m_out_addr; end
          m_out = 1'b0; m_killed = 1'b0;
        end else if (PCSrcE && !m_killed) begin
          m_killed = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TMO) m_err = 1'b1;
        end
      end else if (exp_req) begin
        if (ack) begin fill = 1'b1; fill_addr = m_pc; end
        else begin m_out = 1'b1; m_out_addr = m_pc; m_killed = 1'b0; m_wait = 0; end
      end
      if (PCSrcE) m_pc = {PCTargetE[31:2], 2'b00};
      else if (fill) m_pc = m_pc + 32'd4;
      if (m_err || PCSrcE) m_valid = 1'b0;
      else if (fill) begin m_valid = 1'b1; m_instr = mem_word(fill_addr); m_pcf = fill_addr; end
      else if (consume) m_valid = 1'b0;
    end
    #1;
    check_eq("ValidF", {31'd0, ValidF}, {31'd0, m_valid});
    check_eq("InstrF", InstrF, m_instr);
    check_eq("PCF", PCF, m_pcf);
    check_eq("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    @(negedge clk);
  endtask

  task automatic run(input int n, input int lat, input int st, input int rd);
    lat_mode = lat; stall_pct = st; redir_pct = rd;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; PCSrcE = 1'b0; StallD = 1'b0;
    #2;
    check_reset(tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    lat_mode = 0; stall_pct = 0; redir_pct = 0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(8, 0, 0, 0);      // zero-latency streaming across the 2^32 wrap
    run(15, 3, 0, 0);     // latency 3
    run(5, 0, 100, 0);    // slot full, decode stalled
    run(4, 0, 0, 0);
    run(300, 3, 20, 15);  // redirects during WAIT/KILL and on ack
    run(1500, 99, 30, 10);
    run(25, -1, 0, 0);    // memory never answers
    check_eq("fetch_err_set", {31'd0, fetch_err}, 32'd1);
    run(10, 0, 30, 50);   // redirects ignored after error
    check_eq("fetch_err_sticky", {31'd0, fetch_err}, 32'd1);
    do_reset("rst_after_err");
    run(200, 99, 25, 10);
    lat_mode = 3;
    run(4, 3, 0, 0);      // abandon an outstanding request with reset
    do_reset("rst_mid_txn");
    run(300, 99, 25, 10);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the Fetch stage against a variable-latency instruction memory using a req/ack handshake.
- Owns the program counter, issues one outstanding fetch at a time, and fills a one-entry output slot (ValidF/InstrF/PCF) that feeds the IF/ID register.
- Applies Execute-stage redirects (PCSrcE/PCTargetE) and decode back-pressure (StallD).
- Drives StallF toward the hazard unit and reports a memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000: PC after reset. Must be word aligned.
- BOOT_CYCLES, 2: idle cycles after reset release before the first request. 0 means the first request goes out in the first cycle after reset.
- TIMEOUT, 16: cycles without ack before entering the error state. Must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- StallD  in  1  downstream cannot take the slot this cycle.
- PCSrcE  in  1  redirect request from Execute.
- PCTargetE  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; held stable while imem_req=1 and ack has not arrived.
- imem_ack  in  1  read data valid this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word, sampled when imem_req & imem_ack.
- ValidF  out  1  slot holds a valid instruction.
- InstrF  out  32  slot instruction.
- PCF  out  32  address of InstrF.
- StallF  out  1  combinational; 1 in any cycle the PC does not advance and no redirect is taken.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous):
  - state=BOOT, pc=RESET_PC, req_addr=RESET_PC, boot/timeout counters=0.
  - ValidF=0, InstrF=0, PCF=0, fetch_err=0, imem_req=0, imem_addr=RESET_PC.
  - Reset asserted mid-transaction abandons the outstanding request; no handshake completion is required.
- Definitions:
  - consume = ValidF & ~StallD.
  - can_accept = ~ValidF | consume.
  - The slot clears on consume unless it is refilled in the same cycle.
- Redirect:
  - PCSrcE=1 in any non-ERR state: ValidF<=0 next edge (flush), pc<={PCTargetE[31:2],2'b00}.
  - Redirect has priority over StallD and over ack.
- Address rules: imem_addr = pc in IDLE, req_addr in WAIT/KILL. pc+4 wraps modulo 2^32.
- FSM:
  - BOOT: imem_req=0; counter runs to BOOT_CYCLES, then -> IDLE.
  - IDLE:
    - imem_req = can_accept & ~PCSrcE; req_addr<=pc when a request is issued.
    - Request with ack in the same cycle: slot<={1,imem_rdata,pc}, pc<=pc+4, stay IDLE (zero-latency memory gives one instruction per cycle).
    - Request without ack: -> WAIT.
  - WAIT:
    - imem_req=1, address held. The slot is empty here by construction.
    - ack & ~PCSrcE: slot<={1,imem_rdata,req_addr}, pc<=pc+4, -> IDLE.
    - ack & PCSrcE: data discarded, -> IDLE.
    - ~ack & PCSrcE: -> KILL.
  - KILL:
    - imem_req=1 with the stale req_addr until ack.
    - ack: discard data, -> IDLE; the next request uses the redirected pc.
    - A further PCSrcE in KILL overwrites pc; stay KILL.
  - ERR:
    - Entered from WAIT/KILL when the timeout counter reaches TIMEOUT with no ack.
    - imem_req=0, ValidF=0, fetch_err=1. Redirects and StallD are ignored; leave only by rst.
- Timeout counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entering WAIT/KILL and on ack; increments each WAIT/KILL cycle without ack.
  - Transition to ERR on the edge where the count would reach TIMEOUT.
- StallF = ~PCSrcE & ~(imem_req & imem_ack & state!=KILL).
- Invariants:
  - At most one request outstanding.
  - imem_addr never changes while a request is unacknowledged.
  - The slot is never overwritten while ValidF & StallD.

Test Plan:
- Zero-latency memory (ack=req), StallD=0, BOOT_CYCLES=2 -> imem_req rises 2 cycles after reset release; PCF=0,4,8,C on consecutive cycles with ValidF held 1; StallF=0 in those cycles.
- Memory latency 3 -> imem_req high 3 cycles per fetch with imem_addr constant; ValidF high one cycle in every 3; PCF steps by 4.
- Slot full with StallD=1 for 5 cycles -> imem_req=0, InstrF/PCF held, StallF=1; StallD falls -> the same-cycle request addresses PCF+4.
- Redirect to 0x100 on the 2nd WAIT cycle (latency 3) -> ValidF=0, KILL holds the stale address until ack, stale data never appears on InstrF; next imem_addr=0x100. Also: redirect coincident with ack -> data dropped, next address 0x100.
- TIMEOUT=16, ack never asserted -> fetch_err=1 and imem_req=0 after 16 WAIT cycles; stays set despite PCSrcE; rst returns to BOOT with all outputs at reset values.
- RESET_PC=32'hFFFF_FFF8, zero-latency memory -> PCF=FFFF_FFF8, FFFF_FFFC, 0000_0000. PCTargetE=0x103 -> next address 0x100.
